// File: rtl/lutram_stress_pkg.sv
// Shared types, constants and helpers for the LUTRAM stress driver.
// States, data patterns and the 10-bit Fibonacci LFSR step.
package lutram_stress_pkg;

    localparam int DATA_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_ADDR,
        PAT_INV,
        PAT_LFSR
    } pat_t;

    function automatic logic [DATA_W-1:0] lfsr_next(
        input logic [DATA_W-1:0] q
    );
        return {q[DATA_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
    endfunction

    function automatic pat_t pat_next(input pat_t p);
        unique case (p)
            PAT_ADDR: return PAT_INV;
            PAT_INV:  return PAT_LFSR;
            default:  return PAT_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/lutram_stress_if.sv
// Port bundle between the stress driver and the LUTRAM array.
// The driver is master; the array answers mem_rdat asynchronously.
interface lutram_stress_if
    import lutram_stress_pkg::*;
#(
    parameter int AW = 8
);
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] mem_rdat;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdat,
        input  mem_rdat
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdat,
        output mem_rdat
    );
endinterface

// File: rtl/lutram_pattern_gen.sv
// Pattern data source shared by write and read sweeps.
// Inputs are next-cycle values so the caller can register the data.
module lutram_pattern_gen
    import lutram_stress_pkg::*;
#(
    parameter int                AW        = 8,
    parameter logic [DATA_W-1:0] LFSR_SEED = 10'h2A5
) (
    input  logic              clk,
    input  logic              rst,
    input  pat_t              pat,
    input  logic [AW-1:0]     addr,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] lfsr_d;
    logic [DATA_W-1:0] base;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = LFSR_SEED;
        else if (step)
            lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign base = DATA_W'(addr);

    always_comb begin
        data = base;
        unique case (pat)
            PAT_ADDR: data = base;
            PAT_INV:  data = ~base;
            PAT_LFSR: data = lfsr_d;
            default:  data = base;
        endcase
    end

endmodule

// File: rtl/lutram_stress_driver.sv
// Write-sweep / read-sweep traffic initiator for the banked LUTRAM.
// Counts read mismatches and records the first failing address.
module lutram_stress_driver
    import lutram_stress_pkg::*;
#(
    parameter int                LUTRAM16X10 = 10,
    parameter int                AW          = $clog2(LUTRAM16X10 * 16),
    parameter int                ITERATIONS  = 4,
    parameter logic [DATA_W-1:0] LFSR_SEED   = 10'h2A5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                inj_err,
    lutram_stress_if.master     mem,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_cnt,
    output logic                first_err_valid,
    output logic [AW-1:0]       first_err_addr,
    output logic [15:0]         iter_cnt
);
    localparam int            DEPTH     = LUTRAM16X10 * 16;
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam logic [15:0]   ITER_LAST = 16'(ITERATIONS - 1);

    state_t            state, state_d;
    pat_t              pat, pat_d;
    logic [AW-1:0]     addr, addr_d;
    logic              we, we_d;
    logic [DATA_W-1:0] data, data_q;
    logic              load, step, clr, wrap;
    logic              cmp_v, miss;
    logic [DATA_W-1:0] cmp_rd, cmp_exp;
    logic [AW-1:0]     cmp_addr;

    lutram_pattern_gen #(
        .AW        (AW),
        .LFSR_SEED (LFSR_SEED)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .pat  (pat_d),
        .addr (addr_d),
        .load (load),
        .step (step),
        .data (data)
    );

    always_comb begin
        state_d = state;
        pat_d   = pat;
        addr_d  = addr;
        we_d    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        clr     = 1'b0;
        wrap    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    clr     = 1'b1;
                    pat_d   = PAT_ADDR;
                    load    = 1'b1;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (addr == LAST) begin
                    state_d = READ;
                    addr_d  = '0;
                    load    = 1'b1;
                end else begin
                    addr_d = addr + 1'b1;
                    step   = 1'b1;
                    we_d   = 1'b1;
                end
            end
            READ: begin
                if (addr == LAST) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr + 1'b1;
                    step   = 1'b1;
                end
            end
            DRAIN: state_d = NEXT;
            NEXT: begin
                pat_d = pat_next(pat);
                wrap  = (pat == PAT_LFSR);
                // ITERATIONS of zero never terminates on its own
                if (wrap && ITERATIONS != 0 &&
                    iter_cnt == ITER_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = WRITE;
                    load    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign miss = cmp_v && (cmp_rd != cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pat             <= PAT_ADDR;
            addr            <= '0;
            we              <= 1'b0;
            data_q          <= '0;
            cmp_v           <= 1'b0;
            cmp_rd          <= '0;
            cmp_exp         <= '0;
            cmp_addr        <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            iter_cnt        <= '0;
        end else begin
            state    <= state_d;
            pat      <= pat_d;
            addr     <= addr_d;
            we       <= we_d;
            data_q   <= data;
            cmp_v    <= (state == READ);
            cmp_rd   <= mem.mem_rdat;
            cmp_exp  <= data_q;
            cmp_addr <= addr;
            if (clr) begin
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
                iter_cnt        <= '0;
            end else begin
                if (miss) begin
                    if (err_cnt != 16'hFFFF)
                        err_cnt <= err_cnt + 16'd1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_addr  <= cmp_addr;
                    end
                end
                if (wrap)
                    iter_cnt <= iter_cnt + 16'd1;
            end
        end
    end

    // injected flip rides on the registered data, write cycles only
    assign mem.mem_addr = addr;
    assign mem.mem_we   = we;
    assign mem.mem_wdat = data_q ^ {{(DATA_W-1){1'b0}}, inj_err & we};

    assign busy = !(state inside {IDLE, DONE});
    assign done = (state == DONE);

endmodule

// File: doc/lutram_stress_driver.md
Name: lutram_stress_driver

Overview:
- Self-checking traffic initiator for the banked 16x10 LUTRAM array under stress test; drives the array's addr/we/wdat and checks its rdat.
- Each run performs write-sweep then read-sweep passes with three data patterns and counts mismatches.
- Sits beside the LUTRAM bank in the stress-test top; status goes to LEDs/UART.

Parameters:
- LUTRAM16X10, 10: number of 16x10 LUTRAM banks; DEPTH = LUTRAM16X10*16.
- AW, $clog2(LUTRAM16X10*16): address width, matching the array's addr port.
- ITERATIONS, 4: full pattern iterations per run; 0 = run until rst.
- LFSR_SEED, 10'h2A5: LFSR seed, nonzero; reloaded at every pass start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured in IDLE or DONE only.
- inj_err  in  1  when high in a WRITE cycle, bit 0 of mem_wdat is inverted; expected data is not.
- mem_addr  out  AW  array address.
- mem_we  out  1  array write enable.
- mem_wdat  out  10  array write data.
- mem_rdat  in  10  array read data; asynchronous, valid in the same cycle as mem_addr.
- busy  out  1  high from the first WRITE cycle until DONE.
- done  out  1  level, high while in DONE.
- err_cnt  out  16  mismatch count; saturates at 16'hFFFF.
- first_err_valid  out  1  a mismatch has been captured this run.
- first_err_addr  out  AW  address of the first mismatch.
- iter_cnt  out  16  completed iterations.

Behaviour:
- Reset: all outputs 0, state IDLE, pattern PAT_ADDR, LFSR = LFSR_SEED.
- Decided interface rule: one clock; reset is synchronous and active-high.
- All mem_* outputs are registered.
- FSM states: IDLE, WRITE, READ, DRAIN, NEXT, DONE.
- IDLE/DONE + start:
  - clear err_cnt, first_err_*, iter_cnt;
  - pattern = PAT_ADDR; LFSR = seed;
  - enter WRITE with mem_addr = 0.
- WRITE:
  - mem_we = 1 for DEPTH cycles, addresses 0..DEPTH-1 ascending;
  - data = pattern(addr, lfsr); LFSR steps once per address;
  - after the address DEPTH-1 cycle, go to READ with addr = 0, we = 0, LFSR reloaded.
- READ:
  - DEPTH cycles, addresses 0..DEPTH-1, expected data regenerated identically;
  - each cycle registers {mem_rdat, expected, addr} into a compare stage;
  - the compare result is evaluated in the following cycle.
- DRAIN: 1 cycle; evaluates the final compare; mem_we = 0.
- NEXT: 1 cycle; pattern advances ADDR -> INV -> LFSR -> ADDR.
  - On wrap, iter_cnt increments.
  - If ITERATIONS != 0 and iter_cnt reaches ITERATIONS, go to DONE; otherwise go to WRITE with addr = 0 and LFSR reloaded.
- Pass length = 2*DEPTH+2 cycles. Iteration length = 3*(2*DEPTH+2); 966 cycles at default.
- Patterns:
  - PAT_ADDR: data = zero-extended/truncated addr to 10 bits.
  - PAT_INV: data = ~PAT_ADDR.
  - PAT_LFSR: data = LFSR state; Fibonacci x^10+x^7+1, shifts left, feedback = q[9]^q[6].
- Mismatch handling: err_cnt += 1 unless already 16'hFFFF. If first_err_valid = 0, capture first_err_addr and set first_err_valid; both are held for the rest of the run.
- Sweep bound: only 0..DEPTH-1 are swept; the unused upper AW-space (e.g. 160..255 at default) is never driven.
- start while busy: ignored. start in DONE: restarts immediately.
- Mid-run rst: returns to IDLE next edge; mem_we = 0 that cycle; all counters 0.
- inj_err: affects write data only. A single injected write on one address yields exactly one mismatch per read of that address in that pass.
- busy and done are never high together.

Decomposition:
- lutram_stress_pkg holds:
  - state enum (6 states) and pattern enum (PAT_ADDR, PAT_INV, PAT_LFSR);
  - DATA_W = 10;
  - LFSR tap constants;
  - function lfsr_next.
- Sub-module lutram_pattern_gen: combinational data from {pattern, addr, lfsr_q} plus the LFSR register with load/step controls. It is instantiated once and shared by the write and read sweeps.

Test Plan:
- Reset, then start with ITERATIONS=1 against a clean array.
  - Required: busy for 966 cycles, done = 1, err_cnt = 0, first_err_valid = 0, iter_cnt = 1.
- inj_err high on the single WRITE cycle at addr 5 of the first PAT_ADDR pass.
  - Required: err_cnt = 1, first_err_addr = 5, and the mismatch is flagged 2 cycles after the addr-5 READ cycle.
- Array model with rdat bit 3 stuck-at-0, one iteration.
  - Required: err_cnt equals the number of addresses whose expected bit 3 = 1 across the 3 passes, and first_err_addr = 8.
- rst asserted mid-READ of pass 2.
  - Required: next cycle state IDLE, mem_we = 0, err_cnt = 0. A new start completes normally.
- start pulsed while busy.
  - Required: no effect on addresses, cycle count or counters. start in DONE clears counters and reruns.
- Model that always returns 10'h000 with ITERATIONS=0, run 200000 cycles.
  - Required: err_cnt saturates at 16'hFFFF without wrapping; iter_cnt keeps incrementing.
